report_framer: RTL and testbench
================================

REPORT_FRAMER -- requirements
Module: report_framer

Interface
REQ-001 Parameter NUM_CH, default 3, number of sensor channels framed per report.
REQ-002 Parameter DIGITS, default 4, BCD digits per channel.
REQ-003 Parameter DATA_WIDTH, default 8, FIFO byte width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-007 tick  input  1  one-cycle report request strobe.
REQ-008 ch_en  input  NUM_CH  per-channel report enable.
REQ-009 ch_valid  input  NUM_CH  per-channel data-valid; low marks sensor error or timeout.
REQ-010 ch_digits  input  NUM_CH*DIGITS*4  BCD. Channel c occupies [c*DIGITS*4 +: DIGITS*4]; most-significant nibble is sent first.
REQ-011 fifo_full  input  1  TX FIFO full, backpressure.
REQ-012 fifo_wr  output  1  one-cycle write strobe to TX FIFO.
REQ-013 fifo_wdata  output  DATA_WIDTH  ASCII byte, valid while fifo_wr=1.
REQ-014 busy  output  1  high from the cycle after an accepted tick until the last byte is written.
REQ-015 overrun  output  1  one-cycle pulse when a tick arrives while busy.

Function
REQ-016 On tick in IDLE, the block SHALL snapshot ch_en, ch_valid and ch_digits into internal registers; later input changes SHALL NOT affect the frame in flight.
REQ-017 Frame format: for each enabled channel in ascending index order, send ASCII 'A'+c, then ':', then DIGITS characters; after the last enabled channel, send 0x0D then 0x0A.
REQ-018 Digit character: BCD 0-9 -> 0x30+value; nibble 0xA-0xF -> '?' (0x3F); if the snapshot ch_valid[c]=0, all digits of that channel -> '-' (0x2D).
REQ-019 State machine: IDLE, ID, SEP, DIG, CR, LF. Transitions: IDLE->ID on tick with a nonzero enable snapshot; ID->SEP; SEP->DIG; DIG->DIG until DIGITS characters are sent; DIG->ID (next enabled channel) or DIG->CR; CR->LF; LF->IDLE.
REQ-020 A state SHALL advance only on a cycle where fifo_wr=1; fifo_wr SHALL be asserted only when fifo_full=0, and SHALL be at most one byte per cycle.
REQ-021 fifo_wr and fifo_wdata SHALL be registered; the first byte SHALL be written the cycle after the tick, provided fifo_full=0 on the tick cycle.
REQ-022 With no backpressure, a frame SHALL take E*(DIGITS+2)+2 consecutive write cycles, where E is the number of enabled channels.
REQ-023 A tick with an all-zero ch_en SHALL produce no writes, SHALL leave busy at 0, and SHALL NOT pulse overrun.
REQ-024 A tick while busy=1, including the LF write cycle, SHALL be dropped, SHALL pulse overrun the next cycle, and SHALL NOT alter the frame.
REQ-025 A tick on the cycle busy returns to 0 (IDLE) SHALL be accepted normally.
REQ-026 Internal digit and channel counters SHALL be sized $clog2 of DIGITS and NUM_CH, with a minimum width of 1, and SHALL wrap to 0 at frame end.

Reset
REQ-027 While rst=0: fifo_wr=0, fifo_wdata=0, busy=0, overrun=0, state=IDLE, and all snapshot registers and counters are 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); after release, no residual bytes SHALL be written until a new tick.

Verification (NUM_CH=3, DIGITS=4)
REQ-029 ch_en=101, ch0=0x1234, ch2=0x0567, all valid, tick, fifo_full=0 -> 14 consecutive writes "A:1234C:0567\r\n" (0x41,0x3A,0x31,0x32,0x33,0x34,0x43,0x3A,0x30,0x35,0x36,0x37,0x0D,0x0A); busy is high for exactly 14 cycles.
REQ-030 Same frame with fifo_full=1 for 5 cycles starting at byte 4 -> fifo_wr=0 during those 5 cycles; the byte sequence is unchanged; total duration is 19 cycles.
REQ-031 ch_en=010, ch_valid[1]=0 -> "B:----\r\n". ch1=0x9A05 with ch_valid[1]=1 -> "B:9?05\r\n".
REQ-032 Tick repeated at byte 6 of a frame -> overrun pulses once; the frame completes unchanged; no second frame is sent.
REQ-033 rst=0 at byte 3 of a frame -> fifo_wr=0 at once; after release with no tick for 50 cycles, zero writes and busy=0.
REQ-034 ch_en=000 then tick -> no writes, busy=0, overrun=0.

Source files
------------

// File: rtl/report_framer.sv
// rtl/report_framer.sv - ASCII report framer for BCD sensor channels into a TX FIFO
module report_framer #(
    parameter int NUM_CH     = 3,
    parameter int DIGITS     = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DIGITS*4-1:0]   ch_digits,
    input  logic                         fifo_full,
    output logic                         fifo_wr,
    output logic [DATA_WIDTH-1:0]        fifo_wdata,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // r_state names the byte that will be written next, not the one on the outputs
    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_SEP,
        S_DIG,
        S_CR,
        S_LF
    } state_t;

    state_t                       r_state;
    logic [NUM_CH-1:0]            r_en;
    logic [NUM_CH-1:0]            r_valid;
    logic [NUM_CH*DIGITS*4-1:0]   r_digits;
    logic [CW-1:0]                r_ch;
    logic [DW-1:0]                r_dig;

    logic [CW:0]                  w_first;
    logic [CW:0]                  w_next;
    logic [3:0]                   w_nib;
    logic                         w_vld;
    logic [7:0]                   w_dig_char;
    logic [7:0]                   w_byte;

    // Lowest enabled channel at or above start; MSB flags that one was found
    function automatic logic [CW:0] f_next(input logic [NUM_CH-1:0] en, input int start);
        logic [CW:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[i] && (i >= start)) begin
                res = {1'b1, CW'(i)};
            end
        end
        return res;
    endfunction

    assign w_first = f_next(ch_en, 0);
    assign w_next  = f_next(r_en, int'(r_ch) + 1);

    // Select the current digit nibble (most significant first) and its channel valid flag
    always_comb begin
        w_nib = '0;
        w_vld = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if ((c == int'(r_ch)) && (d == int'(r_dig))) begin
                    w_nib = r_digits[c*DIGITS*4 + (DIGITS-1-d)*4 +: 4];
                    w_vld = r_valid[c];
                end
            end
        end
    end

    // Map the pending state to its ASCII byte
    always_comb begin
        w_dig_char = 8'h2D;
        if (w_vld) begin
            w_dig_char = (w_nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, w_nib});
        end
        w_byte = 8'h00;
        case (r_state)
            S_ID:    w_byte = 8'h41 + 8'(r_ch);
            S_SEP:   w_byte = 8'h3A;
            S_DIG:   w_byte = w_dig_char;
            S_CR:    w_byte = 8'h0D;
            S_LF:    w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    // Frame sequencer: snapshots on tick, emits one byte per non-full cycle, flags overruns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_en       <= '0;
            r_valid    <= '0;
            r_digits   <= '0;
            r_ch       <= '0;
            r_dig      <= '0;
            fifo_wr    <= 1'b0;
            fifo_wdata <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            fifo_wr <= 1'b0;
            overrun <= tick && busy;
            case (r_state)
                S_IDLE: begin
                    if (busy) begin
                        // LF is on the outputs this cycle; the frame ends here
                        busy <= 1'b0;
                    end else if (tick && w_first[CW]) begin
                        r_en     <= ch_en;
                        r_valid  <= ch_valid;
                        r_digits <= ch_digits;
                        r_ch     <= w_first[CW-1:0];
                        r_dig    <= '0;
                        busy     <= 1'b1;
                        if (!fifo_full) begin
                            fifo_wr    <= 1'b1;
                            fifo_wdata <= DATA_WIDTH'(8'h41 + 8'(w_first[CW-1:0]));
                            r_state    <= S_SEP;
                        end else begin
                            r_state    <= S_ID;
                        end
                    end
                end
                default: begin
                    if (!fifo_full) begin
                        fifo_wr    <= 1'b1;
                        fifo_wdata <= DATA_WIDTH'(w_byte);
                        case (r_state)
                            S_ID:  r_state <= S_SEP;
                            S_SEP: r_state <= S_DIG;
                            S_DIG: begin
                                if (r_dig == DW'(DIGITS - 1)) begin
                                    r_dig <= '0;
                                    if (w_next[CW]) begin
                                        r_ch    <= w_next[CW-1:0];
                                        r_state <= S_ID;
                                    end else begin
                                        r_ch    <= '0;
                                        r_state <= S_CR;
                                    end
                                end else begin
                                    r_dig <= r_dig + DW'(1);
                                end
                            end
                            S_CR: r_state <= S_LF;
                            S_LF: begin
                                r_ch    <= '0;
                                r_dig   <= '0;
                                r_state <= S_IDLE;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_report_framer.sv
// tb/tb_report_framer.sv - scoreboard bench for report_framer
module tb_report_framer;

    localparam int NUM_CH = 3;
    localparam int DIGITS = 4;
    localparam int DBITS  = NUM_CH * DIGITS * 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_valid;
    logic [DBITS-1:0]  ch_digits;
    logic              fifo_full;
    logic              fifo_wr;
    logic [7:0]        fifo_wdata;
    logic              busy;
    logic              overrun;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] exp_q[$];

    report_framer #(.NUM_CH(NUM_CH), .DIGITS(DIGITS), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ch_en      (ch_en),
        .ch_valid   (ch_valid),
        .ch_digits  (ch_digits),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write is checked against the next expected byte
    always @(negedge clk) begin
        if (rst && fifo_wr) begin
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got %02h want none", fifo_wdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (fifo_wdata !== e) begin
                    n_bad++;
                    $display("FAIL byte: got %02h want %02h", fifo_wdata, e);
                end
            end
        end
    end

    task automatic push_frame(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] vld,
                              input logic [DBITS-1:0] dg);
        logic [3:0] nib;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en[c]) begin
                exp_q.push_back(8'h41 + 8'(c));
                exp_q.push_back(8'h3A);
                for (int d = DIGITS - 1; d >= 0; d--) begin
                    nib = dg[c*DIGITS*4 + d*4 +: 4];
                    if (!vld[c])      exp_q.push_back(8'h2D);
                    else if (nib > 9) exp_q.push_back(8'h3F);
                    else              exp_q.push_back(8'h30 + {4'h0, nib});
                end
            end
        end
        if (en != '0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic run_frame(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] vld,
                             input logic [DBITS-1:0] dg, input int fs, input int fl, input int retick,
                             output int busy_c, output int gap_c, output int wr_c, output int first_wr,
                             output int last_wr, output int ovr_c, output int ovr_first);
        busy_c = 0; gap_c = 0; wr_c = 0; first_wr = -1; last_wr = -1; ovr_c = 0; ovr_first = -1;
        ch_en = en; ch_valid = vld; ch_digits = dg; fifo_full = 1'b0; tick = 1'b1;
        push_frame(en, vld, dg);
        @(posedge clk); #1;
        for (int k = 1; k <= 45; k++) begin
            tick      = (k == retick);
            fifo_full = (k >= fs) && (k < fs + fl);
            if (k == 1) begin
                ch_en     = '1;
                ch_valid  = '0;
                ch_digits = {$urandom, $urandom};
            end
            @(negedge clk);
            if (busy) busy_c++;
            if (busy && !fifo_wr) gap_c++;
            if (fifo_wr) begin
                wr_c++;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
            end
            if (overrun) begin
                ovr_c++;
                if (ovr_first < 0) ovr_first = k;
            end
            @(posedge clk); #1;
        end
        tick = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; tick = 1'b0; fifo_full = 1'b0;
        ch_en = '0; ch_valid = '0; ch_digits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (fifo_wr !== 1'b0)     begin n_bad++; $display("FAIL rst_wr: got %b want 0", fifo_wr); end
        n_total++; if (fifo_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %02h want 00", fifo_wdata); end
        n_total++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_total++; if (overrun !== 1'b0)     begin n_bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int b, g, w, f, l, o, of;
        run_frame(3'b101, 3'b111, {16'h0567, 16'h0000, 16'h1234}, 0, 0, 0, b, g, w, f, l, o, of);
        n_total++; if (w !== 14)  begin n_bad++; $display("FAIL basic_writes: got %0d want 14", w); end
        n_total++; if (b !== 14)  begin n_bad++; $display("FAIL basic_busy: got %0d want 14", b); end
        n_total++; if (f !== 1)   begin n_bad++; $display("FAIL basic_first: got %0d want 1", f); end
        n_total++; if (l !== 14)  begin n_bad++; $display("FAIL basic_last: got %0d want 14", l); end
        n_total++; if (g !== 0)   begin n_bad++; $display("FAIL basic_gaps: got %0d want 0", g); end
        n_total++; if (o !== 0)   begin n_bad++; $display("FAIL basic_overrun: got %0d want 0", o); end
        n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL basic_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        int b, g, w, f, l, o, of;
        run_frame(3'b101, 3'b111, {16'h0567, 16'h0000, 16'h1234}, 4, 5, 0, b, g, w, f, l, o, of);
        n_total++; if (w !== 14) begin n_bad++; $display("FAIL bp_writes: got %0d want 14", w); end
        n_total++; if (b !== 19) begin n_bad++; $display("FAIL bp_busy: got %0d want 19", b); end
        n_total++; if (g !== 5)  begin n_bad++; $display("FAIL bp_gaps: got %0d want 5", g); end
        n_total++; if (l !== 19) begin n_bad++; $display("FAIL bp_last: got %0d want 19", l); end
        n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL bp_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_digits;
        int b, g, w, f, l, o, of;
        run_frame(3'b010, 3'b101, {16'h0000, 16'h1234, 16'h0000}, 0, 0, 0, b, g, w, f, l, o, of);
        n_total++; if (w !== 8) begin n_bad++; $display("FAIL invalid_writes: got %0d want 8", w); end
        n_total++; if (b !== 8) begin n_bad++; $display("FAIL invalid_busy: got %0d want 8", b); end
        run_frame(3'b010, 3'b010, {16'h0000, 16'h9A05, 16'h0000}, 0, 0, 0, b, g, w, f, l, o, of);
        n_total++; if (w !== 8) begin n_bad++; $display("FAIL bcd_writes: got %0d want 8", w); end
        n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL digits_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_overrun;
        int b, g, w, f, l, o, of;
        run_frame(3'b101, 3'b111, {16'h0567, 16'h0000, 16'h1234}, 0, 0, 7, b, g, w, f, l, o, of);
        n_total++; if (o !== 1)  begin n_bad++; $display("FAIL ovr_count: got %0d want 1", o); end
        n_total++; if (of !== 8) begin n_bad++; $display("FAIL ovr_cycle: got %0d want 8", of); end
        n_total++; if (w !== 14) begin n_bad++; $display("FAIL ovr_writes: got %0d want 14", w); end
        n_total++; if (b !== 14) begin n_bad++; $display("FAIL ovr_busy: got %0d want 14", b); end
        n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL ovr_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int w;
        ch_en = 3'b101; ch_valid = 3'b111; ch_digits = {16'h0567, 16'h0000, 16'h1234};
        tick = 1'b1;
        push_frame(ch_en, ch_valid, ch_digits);
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (13) begin @(posedge clk); #1; end
        // cycle 14: LF on the outputs, a tick here must be dropped
        tick = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lf_busy: got %b want 1", busy); end
        n_total++; if (fifo_wr !== 1'b1) begin n_bad++; $display("FAIL lf_wr: got %b want 1", fifo_wr); end
        @(posedge clk); #1;
        // cycle 15: idle again, a tick here is accepted
        ch_en = 3'b010; ch_valid = 3'b010; ch_digits = {16'h0000, 16'h9A05, 16'h0000};
        push_frame(ch_en, ch_valid, ch_digits);
        @(negedge clk);
        n_total++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL lf_overrun: got %b want 1", overrun); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
        @(posedge clk); #1;
        tick = 1'b0;
        @(negedge clk);
        n_total++; if (fifo_wr !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got %b want 1", fifo_wr); end
        w = 1;
        repeat (20) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (fifo_wr) w++;
        end
        n_total++; if (w !== 8) begin n_bad++; $display("FAIL b2b_writes: got %0d want 8", w); end
        n_total++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int w, b;
        ch_en = 3'b101; ch_valid = 3'b111; ch_digits = {16'h0567, 16'h0000, 16'h1234};
        tick = 1'b1;
        push_frame(ch_en, ch_valid, ch_digits);
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        n_total++; if (fifo_wr !== 1'b0) begin n_bad++; $display("FAIL midrst_wr: got %b want 0", fifo_wr); end
        n_total++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        w = 0; b = 0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_wr) w++;
            if (busy) b++;
            @(posedge clk); #1;
        end
        n_total++; if (w !== 0) begin n_bad++; $display("FAIL postrst_writes: got %0d want 0", w); end
        n_total++; if (b !== 0) begin n_bad++; $display("FAIL postrst_busy: got %0d want 0", b); end
    endtask

    task automatic test_zero_enable;
        int w, b, o;
        ch_en = 3'b000; ch_valid = 3'b111; ch_digits = {16'h0567, 16'h0000, 16'h1234};
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        w = 0; b = 0; o = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_wr) w++;
            if (busy) b++;
            if (overrun) o++;
            @(posedge clk); #1;
        end
        n_total++; if (w !== 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", w); end
        n_total++; if (b !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", b); end
        n_total++; if (o !== 0) begin n_bad++; $display("FAIL zero_overrun: got %0d want 0", o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_digits();
        test_overrun();
        test_back_to_back();
        test_zero_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
